// File: rtl/noc_eject_port.sv
// Receive-side eject port: keeps flits addressed to LOCAL_ID, buffers them and hands them to the core over valid/ready.
// Optional NOC_EJECT_STATS_EN adds saturating accepted/dropped flit counters.
//
// state   | meaning
// S_IDLE  | output stage empty, core_valid=0
// S_VALID | output stage holds a flit, first cycle offered
// S_STALL | output stage holds a flit the core has not yet taken
module noc_eject_port #(
   parameter logic [3:0] LOCAL_ID = 4'd0,
   parameter int          DEPTH    = 8,
   parameter int          AW       = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] flit_in,
   input  logic       flit_wr,
   output logic       flit_full,
   output logic [7:0] core_data,
   output logic       core_valid,
   input  logic       core_ready,
   output logic       err_misroute,
   output logic       err_ovf,
   input  logic       err_clr
`ifdef NOC_EJECT_STATS_EN
   ,
   output logic [15:0] rx_cnt,
   output logic [15:0] drop_cnt
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_VALID, S_STALL} state_t;

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   state_t        r_state, w_state_nxt;
   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count, w_count_nxt;
   logic [7:0]    r_core_data;
   logic          r_full, r_err_mis, r_err_ovf;
   logic          w_match, w_push, w_pop, w_empty, w_drop_mis, w_drop_ovf;

   assign w_empty    = (r_count == '0);
   assign w_match    = (flit_in[3:0] == LOCAL_ID);
   // A pop in the same cycle frees a slot, so a full FIFO can still take a flit.
   assign w_push     = flit_wr && w_match && ((r_count != FULL_CNT) || w_pop);
   assign w_drop_mis = flit_wr && !w_match;
   assign w_drop_ovf = flit_wr && w_match && !w_push;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_VALID;
            end
         end
         S_VALID, S_STALL: begin
            if (core_ready) begin
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_state_nxt = S_VALID;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_state_nxt = S_STALL;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= flit_in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_full      <= 1'b0;
         r_core_data <= 8'h00;
         r_err_mis   <= 1'b0;
         r_err_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == FULL_CNT);
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) begin
            r_rd_ptr    <= r_rd_ptr + 1'b1;
            r_core_data <= r_mem[r_rd_ptr];
         end
         // Set has priority over clear so a coincident error is never lost.
         r_err_mis <= w_drop_mis || (r_err_mis && !err_clr);
         r_err_ovf <= w_drop_ovf || (r_err_ovf && !err_clr);
      end
   end

   assign flit_full    = r_full;
   assign core_data    = r_core_data;
   assign core_valid   = (r_state != S_IDLE);
   assign err_misroute = r_err_mis;
   assign err_ovf      = r_err_ovf;

`ifdef NOC_EJECT_STATS_EN
   logic [15:0] r_rx_cnt, r_drop_cnt;

   // Unlike the sticky flags, clear wins over a coincident increment here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rx_cnt   <= '0;
         r_drop_cnt <= '0;
      end else if (err_clr) begin
         r_rx_cnt   <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_push && (r_rx_cnt != 16'hFFFF)) r_rx_cnt <= r_rx_cnt + 1'b1;
         if ((w_drop_mis || w_drop_ovf) && (r_drop_cnt != 16'hFFFF))
            r_drop_cnt <= r_drop_cnt + 1'b1;
      end
   end

   assign rx_cnt   = r_rx_cnt;
   assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_noc_eject_port.sv
// Directed bench for noc_eject_port: scoreboard of accepted flits checked against core handshakes,
// plus direct checks of flags, latency, full/overflow boundaries and async reset.
module tb_noc_eject_port;
   localparam logic [3:0] LID = 4'd7;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] flit_in = 8'h00;
   logic       flit_wr = 1'b0;
   logic       core_ready = 1'b0;
   logic       err_clr = 1'b0;
   logic       flit_full, core_valid, err_misroute, err_ovf;
   logic [7:0] core_data;
`ifdef NOC_EJECT_STATS_EN
   logic [15:0] rx_cnt, drop_cnt;
`endif

   noc_eject_port #(.LOCAL_ID(LID), .DEPTH(8), .AW(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .flit_in      (flit_in),
      .flit_wr      (flit_wr),
      .flit_full    (flit_full),
      .core_data    (core_data),
      .core_valid   (core_valid),
      .core_ready   (core_ready),
      .err_misroute (err_misroute),
      .err_ovf      (err_ovf),
      .err_clr      (err_clr)
`ifdef NOC_EJECT_STATS_EN
      ,
      .rx_cnt       (rx_cnt),
      .drop_cnt     (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] f, input bit accept);
      flit_in = f;
      flit_wr = 1'b1;
      if (accept) exp_q.push_back(f);
   endtask

   // Scoreboard and stall-stability monitor, sampled mid-cycle.
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = 8'h00;
   always @(negedge clk) begin
      if (!reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", core_valid, 1);
            check("stall_data", core_data, prev_data);
         end
         if (core_valid && core_ready) begin
            if (exp_q.size() == 0) check("sb_unexpected", exp_q.size(), 1);
            else check("sb_data", core_data, exp_q.pop_front());
         end
         prev_stall = core_valid && !core_ready;
         prev_data  = core_data;
      end
   end

   initial begin
      tick(); tick();
      check("rst_valid", core_valid, 0);
      check("rst_data", core_data, 8'h00);
      check("rst_full", flit_full, 0);
      check("rst_mis", err_misroute, 0);
      check("rst_ovf", err_ovf, 0);
      reset = 1'b1;
      tick();

      // Single flit latency
      core_ready = 1'b1;
      wr(8'h17, 1);
      tick();
      flit_wr = 1'b0;
      check("lat_not_yet", core_valid, 0);
      tick();
      check("lat_valid", core_valid, 1);
      check("lat_data", core_data, 8'h17);
      tick();
      check("lat_one_cycle", core_valid, 0);
      check("lat_mis", err_misroute, 0);
      check("lat_ovf", err_ovf, 0);

      // Misroute, clear, set-wins
      wr(8'h13, 0);
      tick();
      flit_wr = 1'b0;
      check("mis_set", err_misroute, 1);
      tick();
      check("mis_no_out", core_valid, 0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("mis_clr", err_misroute, 0);
      wr(8'h23, 0);
      err_clr = 1'b1;
      tick();
      flit_wr = 1'b0;
      check("mis_set_wins", err_misroute, 1);
      tick();
      err_clr = 1'b0;
      check("mis_clr2", err_misroute, 0);

      // Fill output stage + FIFO, overflow, drain
      core_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         wr(8'h07 | 8'(i << 4), 1);
         tick();
      end
      check("fill_full", flit_full, 1);
      check("fill_no_ovf", err_ovf, 0);
      check("fill_head", core_data, 8'h07);
      wr(8'h97, 0);
      tick();
      flit_wr = 1'b0;
      check("ovf_set", err_ovf, 1);
      check("ovf_still_full", flit_full, 1);
      core_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         check("drain_valid", core_valid, 1);
         check("drain_order", core_data, 8'h07 | 8'(i << 4));
         tick();
      end
      check("drain_idle", core_valid, 0);
      check("drain_not_full", flit_full, 0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("ovf_clr", err_ovf, 0);

      // Push and pop together while full
      core_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         wr(8'h07 | 8'(i << 4), 1);
         tick();
      end
      check("pp_full_before", flit_full, 1);
      wr(8'hA7, 1);
      core_ready = 1'b1;
      tick();
      flit_wr = 1'b0;
      check("pp_no_ovf", err_ovf, 0);
      check("pp_still_full", flit_full, 1);
      check("pp_next_head", core_data, 8'h17);
      repeat (12) tick();
      check("pp_sb_empty", exp_q.size(), 0);
      check("pp_idle", core_valid, 0);

      // Async reset during stall
      core_ready = 1'b0;
      wr(8'h37, 1);
      tick();
      wr(8'h47, 1);
      tick();
      flit_wr = 1'b0;
      tick(); tick();
      check("rs_stalled", core_valid, 1);
      #2 reset = 1'b0;
      #1;
      check("rs_async_valid", core_valid, 0);
      check("rs_async_data", core_data, 8'h00);
      exp_q.delete();
      tick(); tick();
      reset = 1'b1;
      core_ready = 1'b1;
      repeat (3) tick();
      check("rs_empty_valid", core_valid, 0);
      check("rs_empty_full", flit_full, 0);

`ifdef NOC_EJECT_STATS_EN
      check("st_rst_rx", rx_cnt, 0);
      wr(8'h57, 1); tick();
      wr(8'h51, 0); tick();
      wr(8'h67, 1); tick();
      wr(8'h52, 0); tick();
      wr(8'h77, 1); tick();
      flit_wr = 1'b0;
      check("st_rx", rx_cnt, 3);
      check("st_drop", drop_cnt, 2);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("st_clr_rx", rx_cnt, 0);
      check("st_clr_drop", drop_cnt, 0);
      wr(8'h87, 1);
      err_clr = 1'b1;
      tick();
      flit_wr = 1'b0;
      err_clr = 1'b0;
      check("st_clr_wins", rx_cnt, 0);
      repeat (4) tick();
`endif

      repeat (4) tick();
      check("end_sb_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
